// File: rtl/uart_pkg.sv
// Shared types and helpers for the streaming UART transmitter.
// Frame states, parity modes and the parity-bit function.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Even parity makes the total count of ones even; odd makes it odd.
    function automatic logic parity_bit(
        input logic [31:0] word,
        input int          mode
    );
        logic p;
        p = ^word;
        if (mode == PAR_EVEN) begin
            return p;
        end else if (mode == PAR_ODD) begin
            return ~p;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/uart_tx_stream_if.sv
// Valid/ready word stream feeding the UART transmitter.
// The producer (result path) is the master, the transmitter the slave.
interface uart_tx_stream_if #(
    parameter int DATA_W = 16
) ();

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered ready and an explicit level counter.
// Ready is registered from the next level, so a pop while full frees a slot one edge later.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           data_o,
    output logic                   ready_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          ready_q;
    logic          push_ok;

    assign push_ok = push_i & ready_q;

    // Level follows push and pop; both together leave it unchanged.
    always_comb begin
        level_d = level_q + LW'(push_ok) - LW'(pop_i);
    end

    // Pointers, level and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + AW'(1);
            end
            level_q <= level_d;
            ready_q <= (level_d != LW'(DEPTH));
        end
    end

    // Storage is not reset; only pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_q];
    assign ready_o = ready_q;
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter fed by a buffered valid/ready word stream.
// Frames are start, DATA_W bits LSB first, optional parity, then stop bits.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_stream_if.slave             s,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_t                   state_q;
    tx_state_t                   state_d;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_d;
    logic [BIT_W-1:0]            bit_q;
    logic [BIT_W-1:0]            bit_d;
    logic [DATA_W-1:0]           shift_q;
    logic [DATA_W-1:0]           shift_d;
    logic                        par_q;
    logic                        par_d;
    logic                        tx_q;
    logic                        tx_d;
    logic                        busy_q;
    logic                        busy_d;

    logic                        pop;
    logic                        bit_end;
    logic [DATA_W-1:0]           fifo_data;
    logic                        fifo_ready;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (s.s_valid),
        .data_i  (s.s_data),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .ready_o (fifo_ready),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign bit_end = (cnt_q == CNT_LAST);

    // State register plus all datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next state; the last stop bit pops straight into a new start bit.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && bit_q == DATA_LAST) begin
                    state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end && bit_q == STOP_LAST) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Baud counter, bit counter, shift register and latched parity.
    always_comb begin
        cnt_d   = (state_q == ST_IDLE || bit_end) ? '0 : cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_d != state_q) begin
            bit_d = '0;
        end else if (bit_end) begin
            bit_d = bit_q + BIT_W'(1);
        end
        if (pop) begin
            shift_d = fifo_data;
            par_d   = parity_bit(32'(fifo_data), PARITY);
        end else if (state_q == ST_DATA && bit_end) begin
            shift_d = shift_q >> 1;
        end
    end

    // Line level and busy; both land one edge after the FSM, so they stay aligned.
    always_comb begin
        busy_d = (state_q != ST_IDLE) || (!fifo_empty && !pop);
        unique case (state_q)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    assign s.s_ready = fifo_ready;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign level     = fifo_level;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench for uart_tx_stream: three parameter sets, directed words.
// A line monitor decodes every frame and checks it against the expected queue.
module tb_uart_tx_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_stream_if #(.DATA_W(16)) if0 ();
    uart_tx_stream_if #(.DATA_W(8))  if1 ();
    uart_tx_stream_if #(.DATA_W(8))  if2 ();

    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic [2:0] lv0, lv1, lv2;

    uart_tx_stream #(
        .DATA_W(16), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut0 (
        .clk(clk), .rst(rst), .s(if0.slave), .tx(tx0), .busy(busy0), .level(lv0)
    );

    uart_tx_stream #(
        .DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut1 (
        .clk(clk), .rst(rst), .s(if1.slave), .tx(tx1), .busy(busy1), .level(lv1)
    );

    uart_tx_stream #(
        .DATA_W(8), .CLKS_PER_BIT(1), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut2 (
        .clk(clk), .rst(rst), .s(if2.slave), .tx(tx2), .busy(busy2), .level(lv2)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        par;
    } exp_t;

    exp_t        sb[$];
    int          starts[$];
    int          checks = 0;
    int          fails  = 0;
    int          ncyc   = 0;
    int          m_ph[3];
    int          m_k[3];
    logic        m_err[3];
    logic [63:0] m_act[3];
    logic [63:0] m_exp[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One monitor step per DUT per cycle: every cycle of a frame is compared.
    task automatic mon_step(input int id, input logic txv, input int dw,
                            input int cpb, input int par, input int stops);
        int   len;
        int   b;
        logic eb;
        len = (1 + dw + ((par != 0) ? 1 : 0) + stops) * cpb;
        if (m_ph[id] == 0) begin
            if (txv !== 1'b0) return;
            m_k[id] = 0;
            if (sb.size() == 0 || sb[0].id != id) begin
                checks++;
                fails++;
                $display("FAIL unexpected_frame dut=%0d at cycle %0d, none expected", id, ncyc);
                m_ph[id] = 2;
            end else begin
                m_ph[id]  = 1;
                m_err[id] = 1'b0;
                m_act[id] = '0;
                m_exp[id] = '0;
                starts.push_back(ncyc);
            end
        end
        if (m_ph[id] == 1) begin
            b = m_k[id] / cpb;
            if (b == 0) eb = 1'b0;
            else if (b <= dw) eb = sb[0].data[b-1];
            else if (par != 0 && b == dw + 1) eb = sb[0].par;
            else eb = 1'b1;
            if (txv !== eb) m_err[id] = 1'b1;
            if (m_k[id] % cpb == cpb / 2) begin
                m_act[id][b] = txv;
                m_exp[id][b] = eb;
            end
        end
        m_k[id]++;
        if (m_k[id] == len) begin
            if (m_ph[id] == 1) begin
                checks++;
                if (m_err[id]) begin
                    fails++;
                    $display("FAIL frame dut=%0d: got bits %0h expected %0h",
                             id, m_act[id], m_exp[id]);
                end
                void'(sb.pop_front());
            end
            m_ph[id] = 0;
        end
    endtask

    // Monitor process; a reset flushes the expected queue like the DUT FIFO.
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            for (int i = 0; i < 3; i++) m_ph[i] = 0;
            sb.delete();
        end else begin
            mon_step(0, tx0, 16, 1, 0, 1);
            mon_step(1, tx1, 8, 4, 1, 1);
            mon_step(2, tx2, 8, 1, 2, 2);
        end
    end

    function automatic logic rdy_of(input int id);
        case (id)
            0: return if0.s_ready;
            1: return if1.s_ready;
            default: return if2.s_ready;
        endcase
    endfunction

    function automatic logic busy_of(input int id);
        case (id)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic tx_of(input int id);
        case (id)
            0: return tx0;
            1: return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic [2:0] lv_of(input int id);
        case (id)
            0: return lv0;
            1: return lv1;
            default: return lv2;
        endcase
    endfunction

    task automatic drive(input int id, input logic v, input logic [31:0] d);
        case (id)
            0: begin if0.s_valid = v; if0.s_data = d[15:0]; end
            1: begin if1.s_valid = v; if1.s_data = d[7:0]; end
            default: begin if2.s_valid = v; if2.s_data = d[7:0]; end
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_word(input int id, input logic [31:0] d, input logic p);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.par  = p;
        sb.push_back(e);
    endtask

    // Offer one word; acc is the cycle index of the accepting edge.
    task automatic send(input int id, input logic [31:0] d, input logic p, output int acc);
        int n;
        n = 0;
        while (!rdy_of(id) && n < 300) begin
            tick();
            n++;
        end
        if (!rdy_of(id)) begin
            checks++;
            fails++;
            $display("FAIL ready_timeout dut=%0d: got ready 0 required 1", id);
        end
        expect_word(id, d, p);
        drive(id, 1'b1, d);
        acc = ncyc + 1;
        tick();
        drive(id, 1'b0, '0);
    endtask

    task automatic count_busy(input int id, output int n);
        bit seen;
        n    = 0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy_of(id)) begin
                n++;
                seen = 1;
            end else if (seen) begin
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        while ((sb.size() != 0 || m_ph[id] != 0 || busy_of(id)) && n < 2000) begin
            tick();
            n++;
        end
        if (n == 2000) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout dut=%0d: got %0d queued required 0", id, sb.size());
        end
    endtask

    task automatic wait_starts(input int cnt);
        int n;
        n = 0;
        while (starts.size() < cnt && n < 2000) begin
            tick();
            n++;
        end
        if (starts.size() < cnt) begin
            checks++;
            fails++;
            $display("FAIL start_timeout: got %0d frames required %0d", starts.size(), cnt);
        end
    endtask

    task automatic wait_cyc(input int t);
        for (int i = 0; i < 2000 && ncyc < t; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int n;
        int s0;
        int bad;
        int maxlv;
        logic [15:0] w [6];

        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        drive(2, 1'b0, '0);
        rst = 1'b1;
        repeat (3) tick();

        for (int id = 0; id < 3; id++) begin
            chk($sformatf("rst_tx%0d", id), 64'(tx_of(id)), 64'd1);
            chk($sformatf("rst_busy%0d", id), 64'(busy_of(id)), 64'd0);
            chk($sformatf("rst_ready%0d", id), 64'(rdy_of(id)), 64'd1);
            chk($sformatf("rst_level%0d", id), 64'(lv_of(id)), 64'd0);
        end
        rst = 1'b0;
        tick();

        // A5C3 on the default configuration.
        starts.delete();
        send(0, 32'h0000A5C3, 1'b0, acc);
        count_busy(0, n);
        wait_idle(0);
        chk("a5c3_busy_cycles", 64'(n), 64'd18);
        chk("a5c3_start_latency", 64'(starts[0] - acc), 64'd2);

        // 8'h07, even parity, 4 clocks per bit.
        starts.delete();
        send(1, 32'h07, 1'b1, acc);
        count_busy(1, n);
        wait_idle(1);
        chk("x07_busy_cycles", 64'(n), 64'd44);
        chk("x07_start_latency", 64'(starts[0] - acc), 64'd2);

        // 8'h00, odd parity, two stop bits, line idles high after.
        send(2, 32'h00, 1'b1, acc);
        count_busy(2, n);
        wait_idle(2);
        chk("x00_busy_cycles", 64'(n), 64'd12);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx2 !== 1'b1) bad++;
            tick();
        end
        chk("x00_idle_low_cycles", 64'(bad), 64'd0);

        // Six words with valid held high.
        w[0] = 16'h0001; w[1] = 16'h8000; w[2] = 16'hFFFF;
        w[3] = 16'h1234; w[4] = 16'h5A5A; w[5] = 16'hC33C;
        starts.delete();
        maxlv = 0;
        bad   = 0;
        n     = 0;
        for (int i = 0; i < 400 && n < 6; i++) begin
            drive(0, 1'b1, 32'(w[n]));
            if (if0.s_ready) begin
                expect_word(0, 32'(w[n]), 1'b0);
                n++;
            end
            tick();
            if (int'(lv0) > maxlv) maxlv = int'(lv0);
            if (if0.s_ready !== (lv0 != 3'd4)) bad++;
        end
        drive(0, 1'b0, '0);
        wait_idle(0);
        chk("burst_max_level", 64'(maxlv), 64'd4);
        chk("burst_ready_vs_full", 64'(bad), 64'd0);
        chk("burst_frames", 64'(starts.size()), 64'd6);
        bad = 0;
        for (int i = 1; i < starts.size(); i++) begin
            if (starts[i] - starts[i-1] != 18) bad++;
        end
        chk("burst_gaps", 64'(bad), 64'd0);

        // Reset during the data bits of the second of three queued words.
        starts.delete();
        send(0, 32'h1111, 1'b0, acc);
        send(0, 32'h2222, 1'b0, acc);
        send(0, 32'h3333, 1'b0, acc);
        wait_starts(2);
        if (starts.size() >= 2) wait_cyc(starts[1] + 6);
        rst = 1'b1;
        tick();
        chk("midrst_tx", 64'(tx0), 64'd1);
        chk("midrst_level", 64'(lv0), 64'd0);
        chk("midrst_busy", 64'(busy0), 64'd0);
        chk("midrst_ready", 64'(if0.s_ready), 64'd1);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx0 !== 1'b1) bad++;
            tick();
        end
        chk("midrst_line_quiet", 64'(bad), 64'd0);
        chk("midrst_frames", 64'(starts.size()), 64'd2);
        send(0, 32'hBEEF, 1'b0, acc);
        wait_idle(0);
        chk("postrst_frames", 64'(starts.size()), 64'd3);

        // Push on the same edge as the pop, with two words queued.
        starts.delete();
        send(0, 32'h0A0A, 1'b0, acc);
        send(0, 32'h0B0B, 1'b0, acc);
        send(0, 32'h0C0C, 1'b0, acc);
        wait_starts(1);
        s0 = (starts.size() > 0) ? starts[0] : ncyc;
        wait_cyc(s0 + 16);
        chk("pushpop_level_before", 64'(lv0), 64'd2);
        expect_word(0, 32'h0D0D, 1'b0);
        drive(0, 1'b1, 32'h0D0D);
        tick();
        drive(0, 1'b0, '0);
        chk("pushpop_level_after", 64'(lv0), 64'd2);
        wait_idle(0);
        chk("pushpop_frames", 64'(starts.size()), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
